// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-ported data memory.
// One request in flight at a time: IDLE (grant) -> ACCESS (memory cycle) -> RESP (pulse).
module dmem_arbiter #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq0Valid,
  output logic        oReq0Ready,
  input  logic        iReq0Write,
  input  logic [31:0] iReq0Addr,
  input  logic [31:0] iReq0WData,
  input  logic [2:0]  iReq0Funct3,
  output logic        oResp0Valid,
  output logic [31:0] oResp0RData,
  output logic        oResp0Err,
  input  logic        iReq1Valid,
  output logic        oReq1Ready,
  input  logic        iReq1Write,
  input  logic [31:0] iReq1Addr,
  input  logic [31:0] iReq1WData,
  input  logic [2:0]  iReq1Funct3,
  output logic        oResp1Valid,
  output logic [31:0] oResp1RData,
  output logic        oResp1Err,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  output logic [2:0]  oMemFunct3,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemReadData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_last_grant, r_port, r_write;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_funct3;

  logic        w_gnt0, w_gnt1, w_hs;
  logic        w_legal, w_misalign, w_oor, w_err;
  logic [2:0]  w_size;
  logic [32:0] w_end;

  // Grant: a lone requester wins; on contention the port that did not win last time wins.
  always_comb begin
    w_gnt0 = (r_state == S_IDLE) && !iRst && iReq0Valid && (!iReq1Valid || r_last_grant);
    w_gnt1 = (r_state == S_IDLE) && !iRst && iReq1Valid && (!iReq0Valid || !r_last_grant);
    w_hs   = w_gnt0 || w_gnt1;
  end

  // Error classification of the latched request; end address kept in 33 bits so it cannot wrap.
  always_comb begin
    case (r_funct3[1:0])
      2'd0:    w_size = 3'd1;
      2'd1:    w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
    w_legal    = r_write ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misalign = ((r_funct3[1:0] == 2'd1) && r_addr[0]) ||
                 ((r_funct3[1:0] == 2'd2) && (r_addr[1:0] != 2'b00));
    w_end      = {1'b0, r_addr} + {30'd0, w_size};
    w_oor      = w_end > 33'(MEM_BYTES);
    w_err      = !w_legal || w_misalign || w_oor;
  end

  always_comb begin
    w_next        = r_state;
    oReq0Ready    = w_gnt0;
    oReq1Ready    = w_gnt1;
    oMemAddress   = '0;
    oMemWriteData = '0;
    oMemFunct3    = '0;
    oMemRead      = 1'b0;
    oMemWrite     = 1'b0;
    oResp0Valid   = 1'b0;
    oResp0RData   = '0;
    oResp0Err     = 1'b0;
    oResp1Valid   = 1'b0;
    oResp1RData   = '0;
    oResp1Err     = 1'b0;
    case (r_state)
      S_IDLE: if (w_hs) w_next = S_ACCESS;
      S_ACCESS: begin
        w_next        = S_RESP;
        oMemAddress   = r_addr;
        oMemWriteData = r_wdata;
        oMemFunct3    = r_funct3;
        oMemRead      = !w_err && !r_write;
        // Reset in this cycle must never let the store commit.
        oMemWrite     = !w_err && r_write && !iRst;
      end
      S_RESP: begin
        w_next = S_IDLE;
        if (r_port) begin
          oResp1Valid = 1'b1;
          oResp1RData = r_rdata;
          oResp1Err   = w_err;
        end else begin
          oResp0Valid = 1'b1;
          oResp0RData = r_rdata;
          oResp0Err   = w_err;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_last_grant <= w_gnt1;
        r_port       <= w_gnt1;
        r_write      <= w_gnt1 ? iReq1Write  : iReq0Write;
        r_addr       <= w_gnt1 ? iReq1Addr   : iReq0Addr;
        r_wdata      <= w_gnt1 ? iReq1WData  : iReq0WData;
        r_funct3     <= w_gnt1 ? iReq1Funct3 : iReq0Funct3;
      end
      if (r_state == S_ACCESS)
        r_rdata <= (w_err || r_write) ? 32'h0 : iMemReadData;
    end
  end

endmodule
